// File: rtl/pcle_pkg.sv
// Shared types and constants for the down timer.
package pcle_pkg;

    // Default counter/load width.
    localparam int unsigned PCLE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pcle_state_e;

endpackage

// File: rtl/pcle_down_timer_if.sv
// Control/status bundle of the down timer; master drives controls, slave is the timer.
interface pcle_down_timer_if
    import pcle_pkg::*;
#(
    parameter int unsigned WIDTH = PCLE_W
) ();

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             cnt_en;
    logic             hold;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             borrow;
    logic             expired;
    logic             busy;

    modport master (
        output load, load_val, cnt_en, hold, auto_reload,
        input  count, borrow, expired, busy
    );

    modport slave (
        input  load, load_val, cnt_en, hold, auto_reload,
        output count, borrow, expired, busy
    );

endinterface

// File: rtl/pcle_dec_step.sv
// Combinational decrement-by-one with zero detect.
module pcle_dec_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] dec,
    output logic             is_zero
);

    // Wraps at zero; the caller never selects dec when is_zero is set.
    assign dec     = value - WIDTH'(1);
    assign is_zero = (value == '0);

endmodule

// File: rtl/pcle_down_timer.sv
// Loadable down timer with optional auto-reload and a one-cycle expiry pulse.
module pcle_down_timer
    import pcle_pkg::*;
#(
    parameter int unsigned WIDTH = PCLE_W
) (
    input logic               clk,
    input logic               rst_n,
    pcle_down_timer_if.slave  bus
);

    pcle_state_e      state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expired_q, expired_d;

    logic [WIDTH-1:0] count_dec;
    logic             count_zero;
    logic             step;
    logic             borrow;

    pcle_dec_step #(
        .WIDTH (WIDTH)
    ) u_dec_step (
        .value   (count_q),
        .dec     (count_dec),
        .is_zero (count_zero)
    );

    assign step   = bus.cnt_en & ~bus.hold & ~bus.load & (state_q == RUN);
    assign borrow = step & count_zero;

    // Next-state: load beats everything, then terminal step, then plain decrement.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;
        if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = RUN;
        end else if (borrow) begin
            expired_d = 1'b1;
            if (bus.auto_reload) begin
                count_d = reload_q;
            end else begin
                state_d = DONE;
            end
        end else if (step) begin
            count_d = count_dec;
        end
    end

    // State, counter, reload and expiry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.borrow  = borrow;
    assign bus.expired = expired_q;
    assign bus.busy    = (state_q == RUN);

endmodule

// File: tb/tb_pcle_down_timer.sv
// Scoreboard bench for pcle_down_timer at WIDTH=8 and WIDTH=4.
module tb_pcle_down_timer;
    import pcle_pkg::*;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    typedef struct {
        int          mode;
        int unsigned cnt;
        int unsigned rld;
        bit          exp;
    } mdl_t;

    typedef struct {
        int unsigned cnt;
        bit          exp;
        bit          busy;
        bit          brw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pcle_down_timer_if #(.WIDTH(8)) bus8 ();
    pcle_down_timer_if #(.WIDTH(4)) bus4 ();

    pcle_down_timer #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    pcle_down_timer #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    exp_t q8[$];
    exp_t q4[$];
    mdl_t m8;
    mdl_t m4;
    int   compared   = 0;
    int   mismatched = 0;

    // Reference: visible outputs this cycle, then the state after the coming edge.
    function automatic void model_step(input mdl_t m, input int unsigned mask, input bit r,
                                       input bit ld, input int unsigned lv, input bit en,
                                       input bit hd, input bit ar, output exp_t e,
                                       output mdl_t n);
        bit stepping;
        stepping = en && !hd && !ld && (m.mode == M_RUN);
        e.cnt  = m.cnt;
        e.exp  = m.exp;
        e.busy = (m.mode == M_RUN);
        e.brw  = stepping && (m.cnt == 0);
        n      = m;
        n.exp  = 1'b0;
        if (!r) begin
            n = '{mode: M_IDLE, cnt: 0, rld: 0, exp: 1'b0};
        end else if (ld) begin
            n.cnt  = lv & mask;
            n.rld  = lv & mask;
            n.mode = M_RUN;
        end else if (stepping) begin
            if (m.cnt == 0) begin
                n.exp = 1'b1;
                if (ar) n.cnt = m.rld;
                else    n.mode = M_DONE;
            end else begin
                n.cnt = m.cnt - 1;
            end
        end
    endfunction

    task automatic chk(input string name, input int w, input logic [31:0] act,
                       input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s (width %0d) at %0t: got %0h required %0h", name, w, $time, act, req);
        end
    endtask

    // One clock of stimulus: drive both timers, queue the expected outputs.
    task automatic cycle(input bit r, input bit ld, input int unsigned lv, input bit en,
                         input bit hd, input bit ar);
        exp_t e;
        rst_n            = r;
        bus8.load        = ld;
        bus8.load_val    = lv[7:0];
        bus8.cnt_en      = en;
        bus8.hold        = hd;
        bus8.auto_reload = ar;
        bus4.load        = ld;
        bus4.load_val    = lv[3:0];
        bus4.cnt_en      = en;
        bus4.hold        = hd;
        bus4.auto_reload = ar;
        model_step(m8, 32'hFF, r, ld, lv, en, hd, ar, e, m8);
        q8.push_back(e);
        model_step(m4, 32'hF, r, ld, lv, en, hd, ar, e, m4);
        q4.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: mid-cycle, compare whatever the DUTs present against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("count",   8, 32'(bus8.count), e.cnt);
                chk("expired", 8, 32'(bus8.expired), 32'(e.exp));
                chk("busy",    8, 32'(bus8.busy), 32'(e.busy));
                chk("borrow",  8, 32'(bus8.borrow), 32'(e.brw));
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("count",   4, 32'(bus4.count), e.cnt);
                chk("expired", 4, 32'(bus4.expired), 32'(e.exp));
                chk("busy",    4, 32'(bus4.busy), 32'(e.busy));
                chk("borrow",  4, 32'(bus4.borrow), 32'(e.brw));
            end
        end
    end

    initial begin
        // Bring both timers to a known state before any expectations are queued.
        rst_n = 1'b0;
        bus8.load = 0; bus8.load_val = 0; bus8.cnt_en = 0; bus8.hold = 0; bus8.auto_reload = 0;
        bus4.load = 0; bus4.load_val = 0; bus4.cnt_en = 0; bus4.hold = 0; bus4.auto_reload = 0;
        @(posedge clk);
        #2;
        m8 = '{mode: M_IDLE, cnt: 0, rld: 0, exp: 1'b0};
        m4 = m8;

        // Reset state, and reset beating a simultaneous load.
        cycle(0, 1, 8'h55, 1, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        // Load 3, count to DONE, then cnt_en ignored.
        cycle(1, 1, 8'h03, 0, 0, 0);
        repeat (7) cycle(1, 0, 0, 1, 0, 0);
        // Load 2 with auto-reload, several periods.
        cycle(1, 1, 8'h02, 1, 0, 1);
        repeat (10) cycle(1, 0, 0, 1, 0, 1);
        // Hold at 5, then resume.
        cycle(1, 1, 8'h07, 0, 0, 0);
        repeat (2) cycle(1, 0, 0, 1, 0, 0);
        repeat (3) cycle(1, 0, 0, 1, 1, 0);
        repeat (3) cycle(1, 0, 0, 1, 0, 0);
        // Load with cnt_en at count 1: load wins, no borrow.
        cycle(1, 1, 8'h03, 0, 0, 0);
        repeat (2) cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 1, 8'hFF, 1, 0, 0);
        repeat (2) cycle(1, 0, 0, 1, 0, 0);
        // Reset at count 0 with a step pending: no expiry afterwards.
        cycle(1, 1, 8'h01, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        repeat (2) cycle(1, 0, 0, 1, 0, 0);
        // Load 0: first step borrows, then DONE ignores further pulses.
        cycle(1, 1, 8'h00, 0, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        repeat (3) begin
            cycle(1, 0, 0, 1, 0, 0);
            cycle(1, 0, 0, 0, 0, 0);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          r, ld, en, hd, ar;
            int unsigned lv;
            r  = ($urandom_range(0, 99) > 1);
            ld = ($urandom_range(0, 11) == 0);
            lv = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom();
            en = ($urandom_range(0, 3) != 0);
            hd = ($urandom_range(0, 4) == 0);
            ar = $urandom_range(0, 1) == 1;
            cycle(r, ld, lv, en, hd, ar);
        end

        @(negedge clk);
        #1;
        compared++;
        if (q8.size() != 0 || q4.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d/%0d pending required 0/0", q8.size(), q4.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pcle_down_timer.md
PCLE_DOWN_TIMER -- requirements
Module: pcle_down_timer

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8: counter and load width in bits.
REQ-002 The block SHALL provide port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1: synchronous, active-low reset.
REQ-004 The block SHALL provide port load, input, 1: load request; highest priority.
REQ-005 The block SHALL provide port load_val, input, WIDTH: value captured on load.
REQ-006 The block SHALL provide port cnt_en, input, 1: count-step enable.
REQ-007 The block SHALL provide port hold, input, 1: inhibits stepping when high.
REQ-008 The block SHALL provide port auto_reload, input, 1: reload on terminal step instead of stopping.
REQ-009 The block SHALL provide port count, output, WIDTH: registered counter value.
REQ-010 The block SHALL provide port borrow, output, 1: combinational terminal-step flag.
REQ-011 The block SHALL provide port expired, output, 1: registered one-cycle expiry pulse.
REQ-012 The block SHALL provide port busy, output, 1: high while in state RUN.

Function
REQ-013 The block SHALL implement states IDLE, RUN and DONE.
REQ-014 step SHALL be defined as cnt_en & ~hold & ~load & (state==RUN).
REQ-015 load SHALL be honoured in every state: count<=load_val, reload_reg<=load_val, state<=RUN, expired<=0.
REQ-016 When step is high and count!=0, the block SHALL set count<=count-1 and remain in RUN.
REQ-017 borrow SHALL equal step & (count==0), with no register delay.
REQ-018 When borrow is high and auto_reload is high, the block SHALL set count<=reload_reg and remain in RUN.
REQ-019 When borrow is high and auto_reload is low, the block SHALL hold count at 0 and enter DONE.
REQ-020 expired SHALL be high exactly the cycle after each borrow and low otherwise.
REQ-021 In IDLE and DONE, cnt_en and hold SHALL be ignored and count SHALL be held.
REQ-022 When load and cnt_en are high together, load SHALL win and no step SHALL occur that cycle.
REQ-023 Loading 0 SHALL enter RUN; the first step then asserts borrow (count 0 -> terminal).
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; count SHALL never wrap below 0 except via the reload path.
REQ-025 auto_reload SHALL be sampled only in the borrow cycle.
REQ-026 busy SHALL equal (state==RUN), taken directly from the registered state.

Reset
REQ-027 While rst_n is low at a clock edge, the block SHALL set state=IDLE, count=0, reload_reg=0 and expired=0; borrow and busy are therefore 0.
REQ-028 Reset SHALL override load and all other inputs in the same cycle.
REQ-029 Reset asserted mid-RUN SHALL abort the count with no expired pulse in the following cycle.

Structure
REQ-030 Package pcle_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default width constant PCLE_W=8.
REQ-031 Sub-module pcle_dec_step SHALL be used: combinational decrement-by-one with zero detect, parameterised by WIDTH.
REQ-032 The top level SHALL contain only the state register, count/reload registers and the expired flop.

Verification
REQ-033 Reset then load=1, load_val=0x03, followed by cnt_en=1 for 5 cycles with auto_reload=0 -> count 3,2,1,0; borrow in cycle 4; expired in cycle 5; state DONE, count 0x00.
REQ-034 Load 0x02 with auto_reload=1 and cnt_en held high -> count 2,1,0,2,1,0,...; borrow every 3rd step; expired one cycle after each borrow.
REQ-035 In RUN at count=0x05, hold=1 for 3 cycles with cnt_en=1 -> count stays 0x05; decrements resume when hold drops.
REQ-036 At count=0x01, load=1, load_val=0xFF and cnt_en=1 together -> count=0xFF next cycle, no borrow.
REQ-037 At count=0x00 in RUN with a step pending, rst_n=0 -> next cycle count=0, state IDLE, expired=0, busy=0.
REQ-038 WIDTH=4, load 0x0 then a single step -> borrow=1; with auto_reload=0 the block enters DONE, and further cnt_en pulses leave count=0x0.
